// File: rtl/stage3_arb_pkg.sv
// -----------------------------------------------------------------------------
// stage3_arb_pkg
// Shared types and constants for the stage-3 memory arbiter.
//   arb_state_t  : arbiter FSM state (idle / fetch granted / data granted)
//   arb_owner_t  : combinational owner of the shared memory port
//   ARB_STARVE_W : width of the fetch-starvation counter (fairness build only)
// -----------------------------------------------------------------------------
package stage3_arb_pkg;

  localparam int ARB_STARVE_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/generic_bus_if.sv
// -----------------------------------------------------------------------------
// generic_bus_if
// Simple request/busy memory bus.
//   addr/wdata/byte_en/ren/wen : request, driven by the requester
//   rdata/busy                 : response, driven by the memory side
// Modports:
//   generic_bus : seen from the slave side (receives requests)
//   cpu         : seen from the requester side (issues requests)
// -----------------------------------------------------------------------------
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ren;
  logic        wen;
  logic        busy;
  logic [3:0]  byte_en;

  modport generic_bus (
    input  addr, ren, wen, wdata, byte_en,
    output rdata, busy
  );

  modport cpu (
    input  rdata, busy,
    output addr, ren, wen, wdata, byte_en
  );
endinterface

// File: rtl/stage3_mem_arbiter.sv
// -----------------------------------------------------------------------------
// stage3_mem_arbiter
// Arbitrates the fetch requester and the memory-stage requester onto a single
// shared memory port. Grant is combinational from ARB_IDLE (zero-cycle grant);
// once a multi-cycle access is under way the owner is held until the memory
// drops busy or the owner withdraws its request.
//
// Ports:
//   CLK            : clock
//   nRST           : asynchronous active-low reset
//   igen_bus_if    : fetch requester (requests in, rdata/busy out)
//   dgen_bus_if    : data requester (requests in, rdata/busy out)
//   out_gen_bus_if : shared memory port
//   grant_d        : data requester owns the shared port this cycle
//   grant_i        : fetch requester owns the shared port this cycle
//
// Parameter:
//   STARVE_LIMIT   : consecutive data completions tolerated while fetch waits
//
// Build option:
//   STAGE3_ARB_FAIRNESS_EN : when defined, a saturating starvation counter
//   lets fetch win the next idle selection after STARVE_LIMIT data
//   completions; otherwise priority is strictly data-first.
// -----------------------------------------------------------------------------
module stage3_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  generic_bus_if.generic_bus igen_bus_if,
  generic_bus_if.generic_bus dgen_bus_if,
  generic_bus_if.cpu         out_gen_bus_if,
  output logic               grant_d,
  output logic               grant_i
);
  import stage3_arb_pkg::*;

  // The limit has to be reachable by the saturating counter.
  if (STARVE_LIMIT < 0 || STARVE_LIMIT > (1 << ARB_STARVE_W) - 1) begin : g_limit_chk
    $error("stage3_mem_arbiter: STARVE_LIMIT out of counter range");
  end

  arb_state_t r_state;
  arb_state_t w_state_next;
  arb_owner_t w_owner;

  logic w_ireq;
  logic w_dreq;
  logic w_fetch_pri;

  assign w_ireq = igen_bus_if.ren | igen_bus_if.wen;
  assign w_dreq = dgen_bus_if.ren | dgen_bus_if.wen;

`ifdef STAGE3_ARB_FAIRNESS_EN
  localparam logic [ARB_STARVE_W-1:0] L_LIMIT = ARB_STARVE_W'(STARVE_LIMIT);

  logic [ARB_STARVE_W-1:0] r_starve_cnt;
  logic                    w_i_done;
  logic                    w_d_done;

  assign w_i_done    = (w_owner == OWN_I) & w_ireq & ~out_gen_bus_if.busy;
  assign w_d_done    = (w_owner == OWN_D) & w_dreq & ~out_gen_bus_if.busy;
  assign w_fetch_pri = (r_starve_cnt >= L_LIMIT);

  // Counts data completions that happened while fetch sat waiting; a data
  // completion implies data owned the port, so fetch cannot be owner here.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= '0;
    end else if (w_i_done) begin
      r_starve_cnt <= '0;
    end else if (w_d_done && w_ireq && (r_starve_cnt != '1)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_fetch_pri = 1'b0;
`endif

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_owner      = OWN_NONE;
    w_state_next = ARB_IDLE;

    out_gen_bus_if.addr    = '0;
    out_gen_bus_if.wdata   = '0;
    out_gen_bus_if.byte_en = '0;
    out_gen_bus_if.ren     = 1'b0;
    out_gen_bus_if.wen     = 1'b0;

    igen_bus_if.rdata = out_gen_bus_if.rdata;
    dgen_bus_if.rdata = out_gen_bus_if.rdata;
    igen_bus_if.busy  = 1'b1;
    dgen_bus_if.busy  = 1'b1;

    // A granted state pins the owner; only idle looks at fresh requests.
    unique case (r_state)
      ARB_GNT_I: w_owner = OWN_I;
      ARB_GNT_D: w_owner = OWN_D;
      default: begin
        if (w_fetch_pri && w_ireq) begin
          w_owner = OWN_I;
        end else if (w_dreq) begin
          w_owner = OWN_D;
        end else if (w_ireq) begin
          w_owner = OWN_I;
        end
      end
    endcase

    unique case (w_owner)
      OWN_I: begin
        out_gen_bus_if.addr    = igen_bus_if.addr;
        out_gen_bus_if.wdata   = igen_bus_if.wdata;
        out_gen_bus_if.byte_en = igen_bus_if.byte_en;
        out_gen_bus_if.ren     = igen_bus_if.ren;
        out_gen_bus_if.wen     = igen_bus_if.wen;
        igen_bus_if.busy       = out_gen_bus_if.busy;
        // Holding the grant only while the owner still asks means a flushed
        // fetch is dropped rather than replayed.
        if (out_gen_bus_if.busy && w_ireq) begin
          w_state_next = ARB_GNT_I;
        end
      end
      OWN_D: begin
        out_gen_bus_if.addr    = dgen_bus_if.addr;
        out_gen_bus_if.wdata   = dgen_bus_if.wdata;
        out_gen_bus_if.byte_en = dgen_bus_if.byte_en;
        out_gen_bus_if.ren     = dgen_bus_if.ren;
        out_gen_bus_if.wen     = dgen_bus_if.wen;
        dgen_bus_if.busy       = out_gen_bus_if.busy;
        if (out_gen_bus_if.busy && w_dreq) begin
          w_state_next = ARB_GNT_D;
        end
      end
      default: ;
    endcase
  end

  assign grant_i = (w_owner == OWN_I);
  assign grant_d = (w_owner == OWN_D);

endmodule

// File: tb/tb_stage3_mem_arbiter.sv
`timescale 1ns/1ps
module tb_stage3_mem_arbiter;

  localparam logic [31:0] RD_MASK = 32'hA5A5_A5A5;

  logic CLK = 1'b0;
  logic nRST;
  logic grant_d;
  logic grant_i;

  always #5 CLK = ~CLK;

  generic_bus_if ibus ();
  generic_bus_if dbus ();
  generic_bus_if obus ();

  stage3_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .igen_bus_if    (ibus),
    .dgen_bus_if    (dbus),
    .out_gen_bus_if (obus),
    .grant_d        (grant_d),
    .grant_i        (grant_i)
  );

  // Memory model: busy for mem_lat cycles of an active request, then done.
  int mem_lat = 0;
  int mem_cnt = 0;
  assign obus.busy  = (obus.ren | obus.wen) && (mem_cnt < mem_lat);
  assign obus.rdata = obus.addr ^ RD_MASK;
  always @(posedge CLK) begin
    if ((obus.ren | obus.wen) && obus.busy) mem_cnt <= mem_cnt + 1;
    else                                    mem_cnt <= 0;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic void push(input logic is_d, input logic [31:0] a,
                               input logic w, input logic [31:0] wd);
    exp_t e;
    e.is_d = is_d; e.addr = a; e.wen = w; e.wdata = wd;
    sb.push_back(e);
  endfunction

  // Monitor: every completed access on the shared port is matched in order.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST && (obus.ren | obus.wen) && !obus.busy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_txn: got addr=%h want no transaction", obus.addr);
        end else begin
          mon_e = sb.pop_front();
          check("txn_grant_d", {31'd0, grant_d}, {31'd0, mon_e.is_d});
          check("txn_grant_i", {31'd0, grant_i}, {31'd0, ~mon_e.is_d});
          check("txn_addr",    obus.addr, mon_e.addr);
          check("txn_wen",     {31'd0, obus.wen}, {31'd0, mon_e.wen});
          check("txn_ren",     {31'd0, obus.ren}, {31'd0, ~mon_e.wen});
          check("txn_byte_en", {28'd0, obus.byte_en}, 32'h0000_000F);
          if (mon_e.wen) check("txn_wdata", obus.wdata, mon_e.wdata);
          check("txn_rdata_i", ibus.rdata, mon_e.addr ^ RD_MASK);
          check("txn_rdata_d", dbus.rdata, mon_e.addr ^ RD_MASK);
          $display("txn %s addr=%h %s wdata=%h t=%0t", mon_e.is_d ? "D" : "I",
                   mon_e.addr, mon_e.wen ? "W" : "R", mon_e.wdata, $time);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic wait_i_done();
    int n = 0;
    do begin @(negedge CLK); n++; end while (ibus.busy && n < 40);
    check("i_done_timeout", {31'd0, ibus.busy}, 32'd0);
  endtask

  task automatic wait_d_done();
    int n = 0;
    do begin @(negedge CLK); n++; end while (dbus.busy && n < 40);
    check("d_done_timeout", {31'd0, dbus.busy}, 32'd0);
  endtask

  task automatic fetch_txn(input logic [31:0] a);
    ibus.addr = a; ibus.ren = 1'b1; ibus.byte_en = 4'hF;
    wait_i_done();
    cyc();
    ibus.ren = 1'b0; ibus.addr = '0;
  endtask

  task automatic data_txn(input logic [31:0] a, input logic w, input logic [31:0] wd);
    dbus.addr = a; dbus.wen = w; dbus.ren = ~w; dbus.wdata = wd; dbus.byte_en = 4'hF;
    wait_d_done();
    cyc();
    dbus.ren = 1'b0; dbus.wen = 1'b0; dbus.addr = '0; dbus.wdata = '0;
  endtask

  // Back-to-back data writes with the request held continuously.
  task automatic data_burst(input int n);
    for (int k = 0; k < n; k++) begin
      dbus.addr = 32'h6000 + 32'(k) * 4; dbus.wen = 1'b1; dbus.ren = 1'b0;
      dbus.wdata = 32'h100 + 32'(k); dbus.byte_en = 4'hF;
      wait_d_done();
      cyc();
    end
    dbus.wen = 1'b0; dbus.addr = '0; dbus.wdata = '0;
  endtask

  initial begin
    ibus.addr = '0; ibus.wdata = '0; ibus.ren = 1'b0; ibus.wen = 1'b0; ibus.byte_en = '0;
    dbus.addr = '0; dbus.wdata = '0; dbus.ren = 1'b0; dbus.wen = 1'b0; dbus.byte_en = '0;
    nRST = 1'b0;

    // Reset state with no requests
    repeat (2) @(negedge CLK);
    check("rst_out_ren", {31'd0, obus.ren}, 32'd0);
    check("rst_out_wen", {31'd0, obus.wen}, 32'd0);
    check("rst_out_addr", obus.addr, 32'd0);
    check("rst_grant_i", {31'd0, grant_i}, 32'd0);
    check("rst_grant_d", {31'd0, grant_d}, 32'd0);
    check("rst_ibusy", {31'd0, ibus.busy}, 32'd1);
    check("rst_dbusy", {31'd0, dbus.busy}, 32'd1);
    cyc();
    nRST = 1'b1;

    // Fetch alone, memory busy two cycles
    mem_lat = 2;
    push(1'b0, 32'h8000_0000, 1'b0, 32'd0);
    fork
      fetch_txn(32'h8000_0000);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge CLK);
          check("f_grant_i", {31'd0, grant_i}, 32'd1);
          check("f_out_addr", obus.addr, 32'h8000_0000);
          check("f_ibusy", {31'd0, ibus.busy}, (c < 2) ? 32'd1 : 32'd0);
        end
      end
    join
    @(negedge CLK);
    check("f_idle_grant_i", {31'd0, grant_i}, 32'd0);
    check("f_idle_ren", {31'd0, obus.ren}, 32'd0);
    cyc();

    // Simultaneous requests: data first, fetch right after with no bubble
    mem_lat = 1;
    push(1'b1, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
    push(1'b0, 32'h0000_2000, 1'b0, 32'd0);
    fork
      data_txn(32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
      fetch_txn(32'h0000_2000);
      begin
        @(negedge CLK);
        check("both_grant_d", {31'd0, grant_d}, 32'd1);
        check("both_grant_i", {31'd0, grant_i}, 32'd0);
        check("both_out_wen", {31'd0, obus.wen}, 32'd1);
        check("both_ibusy", {31'd0, ibus.busy}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        check("both_next_grant_i", {31'd0, grant_i}, 32'd1);
      end
    join

    // Data arrives while fetch is mid-access: fetch keeps the port
    mem_lat = 3;
    push(1'b0, 32'h0000_3000, 1'b0, 32'd0);
    push(1'b1, 32'h0000_4000, 1'b0, 32'd0);
    fork
      fetch_txn(32'h0000_3000);
      begin cyc(); data_txn(32'h0000_4000, 1'b0, 32'd0); end
      begin
        @(negedge CLK);
        for (int c = 0; c < 3; c++) begin
          @(negedge CLK);
          check("hold_grant_i", {31'd0, grant_i}, 32'd1);
          check("hold_dbusy", {31'd0, dbus.busy}, 32'd1);
        end
      end
    join

    // Fetch withdraws in the middle of a 4-cycle access
    mem_lat = 4;
    ibus.addr = 32'h0000_5000; ibus.ren = 1'b1; ibus.byte_en = 4'hF;
    @(negedge CLK);
    check("flush_grant_i", {31'd0, grant_i}, 32'd1);
    cyc();
    cyc();
    ibus.ren = 1'b0; ibus.addr = '0;
    @(negedge CLK);
    check("flush_drop_ren", {31'd0, obus.ren}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("flush_idle_grant_i", {31'd0, grant_i}, 32'd0);
      check("flush_no_reissue", {31'd0, obus.ren}, 32'd0);
    end
    cyc();

    // Data streams while fetch waits: strict priority or fairness hand-off
    mem_lat = 0;
    push(1'b1, 32'h6000, 1'b1, 32'h100);
    push(1'b1, 32'h6004, 1'b1, 32'h101);
    push(1'b1, 32'h6008, 1'b1, 32'h102);
    push(1'b1, 32'h600C, 1'b1, 32'h103);
`ifdef STAGE3_ARB_FAIRNESS_EN
    push(1'b0, 32'h7000, 1'b0, 32'd0);
    push(1'b1, 32'h6010, 1'b1, 32'h104);
    push(1'b1, 32'h6014, 1'b1, 32'h105);
`else
    push(1'b1, 32'h6010, 1'b1, 32'h104);
    push(1'b1, 32'h6014, 1'b1, 32'h105);
    push(1'b0, 32'h7000, 1'b0, 32'd0);
`endif
    fork
      data_burst(6);
      fetch_txn(32'h7000);
    join
    cyc();

    // Reset while data owns the port
    mem_lat = 5;
    dbus.addr = 32'h8000; dbus.wen = 1'b1; dbus.wdata = 32'h55; dbus.byte_en = 4'hF;
    @(negedge CLK);
    check("rstd_grant_d0", {31'd0, grant_d}, 32'd1);
    cyc();
    @(negedge CLK);
    check("rstd_grant_d1", {31'd0, grant_d}, 32'd1);
    cyc();
    dbus.wen = 1'b0; dbus.addr = '0; dbus.wdata = '0;
    nRST = 1'b0;
    #1;
    check("rstd_grant_d", {31'd0, grant_d}, 32'd0);
    check("rstd_out_wen", {31'd0, obus.wen}, 32'd0);
    check("rstd_out_ren", {31'd0, obus.ren}, 32'd0);
    check("rstd_dbusy", {31'd0, dbus.busy}, 32'd1);
    cyc();
    nRST = 1'b1;

    // Normal service after reset
    mem_lat = 0;
    push(1'b1, 32'h9000, 1'b0, 32'd0);
    data_txn(32'h9000, 1'b0, 32'd0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge CLK);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stage3_mem_arbiter.md
STAGE3_MEM_ARBITER -- requirements
Module: stage3_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants tolerated while fetch waits (used only with fairness compiled in).
REQ-002 The block SHALL have port CLK, input, 1, the clock.
REQ-003 The block SHALL have port nRST, input, 1; reset nRST is asynchronous, active-low; clock CLK.
REQ-004 The block SHALL have port igen_bus_if, generic_bus_if.generic_bus modport, fetch-side requester (addr/ren/wen/byte_en/wdata in; rdata/busy out).
REQ-005 The block SHALL have port dgen_bus_if, generic_bus_if.generic_bus modport, memory-stage requester.
REQ-006 The block SHALL have port out_gen_bus_if, generic_bus_if.cpu modport, the single shared memory port.
REQ-007 The block SHALL have port grant_d, output, 1, high when the data requester currently owns the shared port.
REQ-008 The block SHALL have port grant_i, output, 1, high when the fetch requester currently owns the shared port.

Function
REQ-009 The block SHALL implement state arb_state_t {ARB_IDLE, ARB_GNT_I, ARB_GNT_D}.
REQ-010 Owner selection SHALL be combinational in ARB_IDLE (zero-cycle grant): data wins if dren|dwen; else fetch wins if iren|iwen; else no owner.
REQ-011 In ARB_GNT_I or ARB_GNT_D, the owner SHALL be the state, regardless of new requests.
REQ-012 out_gen_bus_if addr/ren/wen/byte_en/wdata SHALL mirror the owner; with no owner, ren=wen=0 and addr/wdata/byte_en SHALL be '0.
REQ-013 rdata SHALL be fanned to both requesters; owner busy SHALL equal out busy; non-owner busy SHALL be 1.
REQ-014 Next state SHALL be the owner's grant state if out busy=1 and the owner still requests; otherwise ARB_IDLE.
REQ-015 A transaction SHALL complete in the cycle the owner requests and out busy=0; the other requester SHALL be selectable in the following cycle with no idle bubble.
REQ-016 If the owner drops its request mid-transaction (e.g. fetch flush), the block SHALL return to ARB_IDLE next cycle and SHALL NOT re-issue it.
REQ-017 Simultaneous I and D requests in ARB_IDLE SHALL grant data (strict priority) unless fairness overrides (REQ-021).
REQ-018 grant_i/grant_d SHALL be one-hot-or-zero and reflect the combinational owner.

Reset
REQ-019 On nRST low, state SHALL be ARB_IDLE and the starvation counter 0; outputs SHALL follow REQ-012/013 with no owner (out ren=wen=0, both busy=1) unless a requester is asserted.
REQ-020 Reset asserted mid-transaction SHALL abandon it; no completion is reported.

Configuration
REQ-021 With macro STAGE3_ARB_FAIRNESS_EN defined, a 3-bit saturating counter SHALL increment on each data completion while fetch requests and is not owner, clear on fetch completion, and when >= STARVE_LIMIT fetch SHALL win the next ARB_IDLE selection.
REQ-022 Without STAGE3_ARB_FAIRNESS_EN, the counter SHALL not exist and priority SHALL be strictly data-first.

Structure
REQ-023 arb_state_t SHALL live in a shared package stage3_arb_pkg together with ARB_STARVE_W = 3.
REQ-024 The block SHALL be a single module; no sub-module.

Verification
REQ-025 Fetch only, iren=1 addr=0x80000000, memory busy 2 cycles -> grant_i 3 cycles, out addr=0x80000000, ibusy=1,1,0, then ARB_IDLE.
REQ-026 I and D both request in ARB_IDLE (D addr=0x1000 wen=1 wdata=0xDEADBEEF) -> grant_d, out wen=1, ibusy=1; grant_i the cycle after D completes.
REQ-027 D request arrives while fetch owns mid-transaction -> fetch keeps port until out busy=0; dbusy=1 throughout.
REQ-028 Fetch owner drops iren at cycle 2 of a 4-cycle access -> ARB_IDLE next cycle, out ren=0, no re-issue.
REQ-029 With STAGE3_ARB_FAIRNESS_EN, STARVE_LIMIT=4, D requests continuously while iren=1 -> after 4 D completions fetch is granted; counter=0 after fetch completes.
REQ-030 nRST asserted during ARB_GNT_D -> state ARB_IDLE immediately, out ren=wen=0 with no requests.
